mc_core_param: RTL and testbench
================================

Name: mc_core_param

Overview:
- Parametrised multi-cycle successor to the team's single-cycle MIPS-subset core.
- Same 32-bit instruction encoding as the single-cycle core. Unified instruction/data word memory.
- Adds explicit FSM sequencing, reset, a bench load port, a debug read port, and halt/error status. The halt instruction raises a status flag and prints nothing.
- Used as the execution engine for the sorting and benchmark programs.

Parameters:
- DATA_W, 32, register/memory word width; must be >= 32 (instruction occupies bits [31:0]).
- ADDR_W, 10, word-address width; memory depth = 2**ADDR_W.
- NUM_REGS, 32, register-file entries; must be a power of two, 8..32.
- RESET_PC, 10, PC value loaded at reset.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; leaves IDLE and begins fetch at current PC
- ld_en  in  1  memory write from bench; honoured only in IDLE or HALT
- ld_addr  in  ADDR_W  load address
- ld_data  in  DATA_W  load data
- dbg_addr  in  ADDR_W  debug read address
- dbg_data  out  DATA_W  combinational mem[dbg_addr]
- busy  out  1  high in any state except IDLE/HALT
- halted  out  1  high in HALT
- err  out  1  sticky; illegal opcode/funct detected
- pc_out  out  ADDR_W  current PC
- instr_cnt  out  32  retired instructions, saturating
- out  out  DATA_W  last value written to a register (rd/rt), or loaded by lw

Behaviour:
- Reset (async, rst_n=0):
  - Outputs and status: state=IDLE, pc=RESET_PC, out=0, instr_cnt=0, err=0, halted=0, busy=0.
  - Registers: all cleared.
  - Memory is NOT cleared.
  - Reset mid-instruction aborts it; a pending sw does not commit.
- States:
  - IDLE -(start)-> FETCH -> DECODE -> EXEC.
  - EXEC -> MEM for lw/sw. EXEC -> WB for ALU/imm ops. EXEC -> FETCH for branch/jump/jr.
  - MEM -> WB for lw. MEM -> FETCH for sw. WB -> FETCH.
  - DECODE -> HALT on opcode 111111 or an illegal opcode/funct (the latter sets err).
  - HALT is terminal until reset.
- Latency:
  - ALU/imm: 4 cycles. lw: 5. sw: 4. branch/jump: 3. halt: 2 to HALT.
  - instr_cnt increments on the final cycle of each retired instruction; halt counts as retired.
- Register file:
  - Register index = field modulo NUM_REGS. Register 0 reads 0; writes to it are discarded, but out still updates.
- R-type (op 000000) funct:
  - 100000/100001 add; 100010/100011 sub; 100100 and; 100101 or.
  - 101010 slt: unsigned compare, result 1/0.
  - 000000 sll: rt<<shamt. 000010 srl: rt>>shamt, logical.
  - 001000 jr: pc=rs[ADDR_W-1:0].
- I-type:
  - 001000/001001 addi: sign-extended imm. 001100 andi, 001101 ori: zero-extended imm.
  - 001010 slti: rt = (rs < sext(imm)) unsigned.
  - 100011 lw, 101011 sw: address = (rs + sext(imm)) mod 2**ADDR_W, i.e. wrap-around.
- Branches:
  - 000100 beq / 000101 bne: taken -> pc = pc+1+sext(imm); not taken -> pc+1.
  - Both are PC-relative. The old bne absolute-target form is retired.
- Jumps:
  - 000010 j: pc = target[ADDR_W-1:0].
  - 000011 jal: reg[NUM_REGS-1] = pc+1, then jump.
- Arithmetic is modulo 2**DATA_W; no overflow traps. PC arithmetic wraps mod 2**ADDR_W.
- Simultaneous events:
  - start while busy/halted: ignored.
  - ld_en while busy: ignored.
  - ld_en and start in the same IDLE cycle: the load commits, then the fetch sees the new data the following cycle.
  - dbg_data reflects a memory write from the cycle after the write.

Optional Feature:
- Macro: MC_CORE_EXT_BRANCH_EN.
- Defined: PC-relative compare branches, unsigned: 000110 blt (rs<rt), 000111 bgt (rs>rt), 011111 ble (rs<=rt), 001111 bge (rs>=rt). Each takes 3 cycles; target = pc+1+sext(imm).
- Undefined: these opcodes are illegal -> HALT with err=1.

Test Plan:
- Bubble sort:
  - Stimulus: load {12,44,60,30,32,10,14,27,9,19} at 0..9 and the PC-relative bubble-sort program at 10, then pulse start.
  - Response: halted=1, err=0; dbg reads 0..9 = {9,10,12,14,19,27,30,32,44,60}.
- Latency per class: program addi r1,r0,5; lw r2,0(r0); sw; beq taken; halt.
  - busy cycle counts are 4, 5, 4, 3, 2. instr_cnt=5. out=mem[0] after lw.
- Register 0: add r0,r1,r1 with r1=7.
  - r0 still reads 0. out=14.
- Address wrap: lw with rs=1023, imm=2, ADDR_W=10.
  - Reads mem[1].
- Illegal opcode: opcode 000110 with the macro undefined.
  - HALT, err=1, pc_out=address of that instruction. With the macro defined, it executes as blt.
- Reset mid-run: drop rst_n during MEM of a sw.
  - Target word unchanged. State=IDLE, pc_out=10, instr_cnt=0.
  - A start pulse while busy after restart has no effect.

Source files
------------

// File: rtl/mc_core_param.sv
// Multi-cycle MIPS-subset core with unified word memory, bench load port and debug read port.
// Optional compare branches (blt/bgt/ble/bge) are enabled by defining MC_CORE_EXT_BRANCH_EN.
module mc_core_param #(
   parameter int DATA_W   = 32,
   parameter int ADDR_W   = 10,
   parameter int NUM_REGS = 32,
   parameter int RESET_PC = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data,
   output logic              busy,
   output logic              halted,
   output logic              err,
   output logic [ADDR_W-1:0] pc_out,
   output logic [31:0]       instr_cnt,
   output logic [DATA_W-1:0] out
);
   localparam int RI_W = $clog2(NUM_REGS);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   localparam logic [2:0] C_ALU  = 3'd0;
   localparam logic [2:0] C_LW   = 3'd1;
   localparam logic [2:0] C_SW   = 3'd2;
   localparam logic [2:0] C_BR   = 3'd3;
   localparam logic [2:0] C_JMP  = 3'd4;
   localparam logic [2:0] C_HALT = 3'd5;
   localparam logic [2:0] C_ILL  = 3'd6;

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rf  [NUM_REGS];

   logic [2:0]        state;
   logic [ADDR_W-1:0] pc;
   logic [31:0]       ir;
   logic [DATA_W-1:0] a_q, b_q, res_q;
   logic [ADDR_W-1:0] addr_q;

   logic [5:0]        op, funct;
   logic [4:0]        shamt;
   logic [RI_W-1:0]   rs_i, rt_i, rd_i;
   logic [DATA_W-1:0] simm, zimm;
   logic [ADDR_W-1:0] pc_inc, br_tgt;
   logic [2:0]        cls;
   logic [DATA_W-1:0] alu;
   logic              taken, retire;
   logic              rf_we, mem_we;
   logic [RI_W-1:0]   rf_idx;
   logic [DATA_W-1:0] rf_wd, mem_wd;
   logic [ADDR_W-1:0] mem_wa;

   assign op     = ir[31:26];
   assign funct  = ir[5:0];
   assign shamt  = ir[10:6];
   assign rs_i   = ir[21 +: RI_W];
   assign rt_i   = ir[16 +: RI_W];
   assign rd_i   = ir[11 +: RI_W];
   assign simm   = {{(DATA_W-16){ir[15]}}, ir[15:0]};
   assign zimm   = {{(DATA_W-16){1'b0}}, ir[15:0]};
   assign pc_inc = pc + ADDR_W'(1);
   assign br_tgt = pc_inc + simm[ADDR_W-1:0];

   assign busy      = (state != S_IDLE) && (state != S_HALT);
   assign halted    = (state == S_HALT);
   assign pc_out    = pc;
   assign dbg_data  = mem[dbg_addr];

   always_comb begin
      cls = C_ILL;
      case (op)
         6'b000000: begin
            case (funct)
               6'b100000, 6'b100001, 6'b100010, 6'b100011,
               6'b100100, 6'b100101, 6'b101010, 6'b000000,
               6'b000010: cls = C_ALU;
               6'b001000: cls = C_JMP;
               default:   cls = C_ILL;
            endcase
         end
         6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001010: cls = C_ALU;
         6'b100011: cls = C_LW;
         6'b101011: cls = C_SW;
         6'b000100, 6'b000101: cls = C_BR;
`ifdef MC_CORE_EXT_BRANCH_EN
         6'b000110, 6'b000111, 6'b011111, 6'b001111: cls = C_BR;
`endif
         6'b000010, 6'b000011: cls = C_JMP;
         6'b111111: cls = C_HALT;
         default:   cls = C_ILL;
      endcase
   end

   always_comb begin
      alu = '0;
      if (op == 6'b000000) begin
         case (funct)
            6'b100000, 6'b100001: alu = a_q + b_q;
            6'b100010, 6'b100011: alu = a_q - b_q;
            6'b100100: alu = a_q & b_q;
            6'b100101: alu = a_q | b_q;
            6'b101010: alu = DATA_W'(a_q < b_q);
            6'b000000: alu = b_q << shamt;
            6'b000010: alu = b_q >> shamt;
            default:   alu = '0;
         endcase
      end else begin
         case (op)
            6'b001000, 6'b001001: alu = a_q + simm;
            6'b001100: alu = a_q & zimm;
            6'b001101: alu = a_q | zimm;
            6'b001010: alu = DATA_W'(a_q < simm);
            default:   alu = '0;
         endcase
      end
   end

   // all compare branches are unsigned and share the pc+1+sext(imm) target
   always_comb begin
      taken = 1'b0;
      case (op)
         6'b000100: taken = (a_q == b_q);
         6'b000101: taken = (a_q != b_q);
`ifdef MC_CORE_EXT_BRANCH_EN
         6'b000110: taken = (a_q <  b_q);
         6'b000111: taken = (a_q >  b_q);
         6'b011111: taken = (a_q <= b_q);
         6'b001111: taken = (a_q >= b_q);
`endif
         default:   taken = 1'b0;
      endcase
   end

   always_comb begin
      retire = 1'b0;
      case (state)
         S_DECODE: retire = (cls == C_HALT);
         S_EXEC:   retire = (cls == C_BR) || (cls == C_JMP);
         S_MEM:    retire = (cls == C_SW);
         S_WB:     retire = 1'b1;
         default:  retire = 1'b0;
      endcase
   end

   // jal links in EXEC; every other register write happens in WB
   always_comb begin
      rf_we  = 1'b0;
      rf_idx = '0;
      rf_wd  = '0;
      if (state == S_WB) begin
         rf_we  = 1'b1;
         rf_idx = (op == 6'b000000) ? rd_i : rt_i;
         rf_wd  = res_q;
      end else if (state == S_EXEC && op == 6'b000011) begin
         rf_we  = 1'b1;
         rf_idx = RI_W'(NUM_REGS - 1);
         rf_wd  = DATA_W'(pc_inc);
      end
   end

   always_comb begin
      mem_we = 1'b0;
      mem_wa = ld_addr;
      mem_wd = ld_data;
      if (state == S_MEM && cls == C_SW) begin
         mem_we = rst_n;
         mem_wa = addr_q;
         mem_wd = b_q;
      end else if (ld_en && (state == S_IDLE || state == S_HALT)) begin
         mem_we = rst_n;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else if (rf_we && rf_idx != '0) begin
         rf[rf_idx] <= rf_wd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         pc        <= ADDR_W'(RESET_PC);
         ir        <= '0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         addr_q    <= '0;
         out       <= '0;
         instr_cnt <= '0;
         err       <= 1'b0;
      end else begin
         if (retire && instr_cnt != 32'hFFFF_FFFF) instr_cnt <= instr_cnt + 32'd1;
         if (rf_we) out <= rf_wd;
         case (state)
            S_IDLE:  if (start) state <= S_FETCH;
            S_FETCH: begin
               ir    <= mem[pc][31:0];
               state <= S_DECODE;
            end
            S_DECODE: begin
               a_q <= rf[rs_i];
               b_q <= rf[rt_i];
               case (cls)
                  C_HALT:  state <= S_HALT;
                  C_ILL: begin
                     state <= S_HALT;
                     err   <= 1'b1;
                  end
                  default: state <= S_EXEC;
               endcase
            end
            S_EXEC: begin
               case (cls)
                  C_ALU: begin
                     res_q <= alu;
                     state <= S_WB;
                  end
                  C_LW, C_SW: begin
                     addr_q <= ADDR_W'(a_q + simm);
                     state  <= S_MEM;
                  end
                  C_BR: begin
                     pc    <= taken ? br_tgt : pc_inc;
                     state <= S_FETCH;
                  end
                  C_JMP: begin
                     pc    <= (op == 6'b000000) ? a_q[ADDR_W-1:0] : ADDR_W'(ir[25:0]);
                     state <= S_FETCH;
                  end
                  default: state <= S_HALT;
               endcase
            end
            S_MEM: begin
               if (cls == C_LW) begin
                  res_q <= mem[addr_q];
                  state <= S_WB;
               end else begin
                  pc    <= pc_inc;
                  state <= S_FETCH;
               end
            end
            S_WB: begin
               pc    <= pc_inc;
               state <= S_FETCH;
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mc_core_param.sv
// Directed bench for mc_core_param: sort program, per-class latency, r0, wrap, illegal op, reset mid-run.
module tb_mc_core_param;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 10;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              ld_en = 1'b0;
   logic [ADDR_W-1:0] ld_addr = '0;
   logic [DATA_W-1:0] ld_data = '0;
   logic [ADDR_W-1:0] dbg_addr = '0;
   logic [DATA_W-1:0] dbg_data;
   logic              busy, halted, err;
   logic [ADDR_W-1:0] pc_out;
   logic [31:0]       instr_cnt;
   logic [DATA_W-1:0] out;

   int total = 0;
   int bad   = 0;
   int lat[$];

   localparam logic [31:0] HALT = 32'hFC00_0000;

   mc_core_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(32), .RESET_PC(10)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .ld_en(ld_en), .ld_addr(ld_addr),
      .ld_data(ld_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .busy(busy),
      .halted(halted), .err(err), .pc_out(pc_out), .instr_cnt(instr_cnt), .out(out)
   );

   always #5 clk = ~clk;

   // all tasks are entered and left just after a falling edge
   task automatic load(input int a, input logic [31:0] d);
      ld_en = 1'b1; ld_addr = ADDR_W'(a); ld_data = d;
      @(negedge clk);
      ld_en = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_halt(input int max_cyc, input string name);
      int bc = 0;
      logic [31:0] prev = instr_cnt;
      lat.delete();
      for (int i = 0; i < max_cyc; i++) begin
         if (instr_cnt != prev) begin
            lat.push_back(bc);
            bc = 0;
            prev = instr_cnt;
         end
         if (busy) bc++;
         if (halted) return;
         @(negedge clk);
      end
      total++; bad++;
      $display("FAIL %s timeout: halted=%0b after %0d cycles, required 1", name, halted, max_cyc);
   endtask

   task automatic chk_mem(input int a, input logic [31:0] exp, input string name);
      dbg_addr = ADDR_W'(a);
      #1;
      total++;
      if (dbg_data !== exp) begin
         bad++;
         $display("FAIL %s mem[%0d]: got %h, required %h", name, a, dbg_data, exp);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      total++;
      if ({busy, halted, err} !== 3'b000 || pc_out !== 10'd10 || instr_cnt !== 32'd0 || out !== '0) begin
         bad++;
         $display("FAIL reset_state: busy=%b halted=%b err=%b pc=%0d cnt=%0d out=%h, required 0 0 0 10 0 0",
                  busy, halted, err, pc_out, instr_cnt, out);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_bubble_sort();
      logic [31:0] data [10] = '{12, 44, 60, 30, 32, 10, 14, 27, 9, 19};
      logic [31:0] srt  [10] = '{9, 10, 12, 14, 19, 27, 30, 32, 44, 60};
      logic [31:0] prog [13] = '{32'h2001_0009, 32'h2002_0000, 32'h8C43_0000, 32'h8C44_0001,
                                 32'h0083_282A, 32'h10A0_0002, 32'hAC44_0000, 32'hAC43_0001,
                                 32'h2042_0001, 32'h1441_FFF8, 32'h2021_FFFF, 32'h1420_FFF5, HALT};
      do_reset();
      for (int i = 0; i < 10; i++) load(i, data[i]);
      for (int i = 0; i < 13; i++) load(10 + i, prog[i]);
      pulse_start();
      run_halt(20000, "sort");
      total++;
      if (halted !== 1'b1 || err !== 1'b0) begin
         bad++;
         $display("FAIL sort_status: halted=%b err=%b, required 1 0", halted, err);
      end
      for (int i = 0; i < 10; i++) chk_mem(i, srt[i], "sort");
   endtask

   task automatic test_latency();
      int exp_lat [5] = '{4, 5, 4, 3, 2};
      do_reset();
      load(0, 32'h0000_1234);
      load(1, 32'h0000_0000);
      load(10, 32'h2001_0005);   // addi r1,r0,5
      load(11, 32'h8C02_0000);   // lw   r2,0(r0)
      load(12, 32'hAC01_0001);   // sw   r1,1(r0)
      load(13, 32'h1000_0000);   // beq  r0,r0,+0
      load(14, HALT);
      pulse_start();
      run_halt(200, "latency");
      total++;
      if (lat.size() != 5) begin
         bad++;
         $display("FAIL latency_count: got %0d retire events, required 5", lat.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            total++;
            if (lat[i] != exp_lat[i]) begin
               bad++;
               $display("FAIL latency_%0d: got %0d busy cycles, required %0d", i, lat[i], exp_lat[i]);
            end
         end
      end
      total++;
      if (instr_cnt !== 32'd5 || out !== 32'h1234 || pc_out !== 10'd14) begin
         bad++;
         $display("FAIL latency_final: cnt=%0d out=%h pc=%0d, required 5 1234 14", instr_cnt, out, pc_out);
      end
      chk_mem(1, 32'd5, "latency_sw");
   endtask

   task automatic test_reg0();
      do_reset();
      load(2, 32'h0000_DEAD);
      load(10, 32'h0000_003F);   // illegal funct, replaced in the start cycle
      load(11, 32'h0021_0020);   // add r0,r1,r1
      load(12, 32'hAC00_0002);   // sw  r0,2(r0)
      load(13, HALT);
      ld_en = 1'b1; ld_addr = 10'd10; ld_data = 32'h2001_0007;  // addi r1,r0,7 with start
      start = 1'b1;
      @(negedge clk);
      ld_en = 1'b0; start = 1'b0;
      run_halt(200, "reg0");
      total++;
      if (err !== 1'b0 || out !== 32'd14 || instr_cnt !== 32'd4) begin
         bad++;
         $display("FAIL reg0: err=%b out=%0d cnt=%0d, required 0 14 4", err, out, instr_cnt);
      end
      chk_mem(2, 32'd0, "reg0_reads_zero");
   endtask

   task automatic test_addr_wrap();
      do_reset();
      load(1, 32'h0000_CAFE);
      load(10, 32'h2001_03FF);   // addi r1,r0,1023
      load(11, 32'h8C22_0002);   // lw   r2,2(r1)
      load(12, HALT);
      pulse_start();
      run_halt(200, "wrap");
      total++;
      if (out !== 32'h0000_CAFE) begin
         bad++;
         $display("FAIL addr_wrap: out=%h, required 0000cafe", out);
      end
   endtask

   task automatic test_illegal();
      do_reset();
      load(10, 32'h2001_0001);   // addi r1,r0,1
      load(11, 32'h1800_0000);   // opcode 000110 (blt r0,r0,+0)
      load(12, HALT);
      pulse_start();
      run_halt(200, "illegal");
`ifdef MC_CORE_EXT_BRANCH_EN
      total++;
      if (halted !== 1'b1 || err !== 1'b0 || pc_out !== 10'd12) begin
         bad++;
         $display("FAIL blt_exec: halted=%b err=%b pc=%0d, required 1 0 12", halted, err, pc_out);
      end
`else
      total++;
      if (halted !== 1'b1 || err !== 1'b1 || pc_out !== 10'd11) begin
         bad++;
         $display("FAIL illegal_op: halted=%b err=%b pc=%0d, required 1 1 11", halted, err, pc_out);
      end
`endif
   endtask

   task automatic test_reset_mid_run();
      int n;
      do_reset();
      load(3, 32'h0000_0077);
      load(100, 32'h0000_1111);
      load(10, 32'h2001_0055);   // addi r1,r0,0x55
      load(11, 32'hAC01_0003);   // sw   r1,3(r0)
      load(12, HALT);
      pulse_start();
      n = 0;
      while (instr_cnt != 32'd1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);   // FETCH -> DECODE -> EXEC -> MEM of the sw
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total++;
      if (busy !== 1'b0 || pc_out !== 10'd10 || instr_cnt !== 32'd0 || halted !== 1'b0) begin
         bad++;
         $display("FAIL midrun_state: busy=%b pc=%0d cnt=%0d halted=%b, required 0 10 0 0",
                  busy, pc_out, instr_cnt, halted);
      end
      chk_mem(3, 32'h77, "midrun_sw_aborted");
      @(negedge clk);
      pulse_start();
      repeat (2) @(negedge clk);
      start = 1'b1; ld_en = 1'b1; ld_addr = 10'd100; ld_data = 32'h0000_0BAD;
      @(negedge clk);
      start = 1'b0; ld_en = 1'b0;
      run_halt(200, "midrun_rerun");
      total++;
      if (instr_cnt !== 32'd3 || pc_out !== 10'd12 || err !== 1'b0) begin
         bad++;
         $display("FAIL midrun_rerun: cnt=%0d pc=%0d err=%b, required 3 12 0", instr_cnt, pc_out, err);
      end
      chk_mem(3, 32'h55, "midrun_sw_commits");
      chk_mem(100, 32'h1111, "busy_load_ignored");
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_bubble_sort();
      test_latency();
      test_reg0();
      test_addr_wrap();
      test_illegal();
      test_reset_mid_run();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
